// File: rtl/result_vector_collector.sv
// Collects scalar accumulator results, applies optional ReLU and signed saturation,
// packs VEC_LEN elements per vector and buffers vectors in a first-word-fall-through FIFO.
module result_vector_collector #(
  parameter int unsigned IN_W       = 20,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned VEC_LEN    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             relu_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [VEC_LEN*OUT_W-1:0]         out_data,
  output logic [VEC_LEN-1:0]               out_sat,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned VEC_W = VEC_LEN * OUT_W;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_LEN - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  // Saturation bounds of the OUT_W signed range, expressed at IN_W width
  localparam logic signed [IN_W-1:0] MAX_IN = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_IN = ~MAX_IN;
  localparam logic [OUT_W-1:0]       MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]       MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    STALL
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [LVL_W-1:0]                level_q, level_d;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;

  logic [VEC_LEN-1:0][OUT_W-1:0]   lane_q;
  logic [VEC_LEN-1:0]              lane_sat_q;
  logic [VEC_W-1:0]                mem_q     [FIFO_DEPTH];
  logic [VEC_LEN-1:0]              sat_mem_q [FIFO_DEPTH];

  logic                            accept_c;
  logic                            pop_c;
  logic                            push_c;
  logic                            last_c;
  logic [OUT_W-1:0]                elem_c;
  logic                            elem_sat_c;
  logic [VEC_LEN-1:0][OUT_W-1:0]   push_vec_c;
  logic [VEC_LEN-1:0]              push_sat_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Element conversion: ReLU wins over saturation, so a clamped negative never flags
  always_comb begin
    elem_c     = in_data[OUT_W-1:0];
    elem_sat_c = 1'b0;
    if (relu_en && in_data[IN_W-1]) begin
      elem_c = '0;
    end else if ($signed(in_data) > MAX_IN) begin
      elem_c     = MAX_OUT;
      elem_sat_c = 1'b1;
    end else if ($signed(in_data) < MIN_IN) begin
      elem_c     = MIN_OUT;
      elem_sat_c = 1'b1;
    end
  end

  // Vector to push: assembled lanes with the in-flight element merged at its lane
  always_comb begin
    push_vec_c = lane_q;
    push_sat_c = lane_sat_q;
    for (int unsigned i = 0; i < VEC_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        push_vec_c[i] = elem_c;
        push_sat_c[i] = elem_sat_c;
      end
    end
  end

  // Handshake-side outputs depend only on registered state
  assign in_ready   = (state_q != STALL);
  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign out_sat    = sat_mem_q[rd_ptr_q];
  assign fifo_level = level_q;

  // Next-state and datapath control
  always_comb begin
    accept_c = 1'b0;
    pop_c    = 1'b0;
    push_c   = 1'b0;
    last_c   = 1'b0;
    idx_d    = idx_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;

    accept_c = in_valid && in_ready;
    pop_c    = out_valid && out_ready;
    last_c   = (idx_q == LAST_IDX);
    push_c   = accept_c && last_c;

    if (accept_c) begin
      idx_d = last_c ? '0 : idx_q + IDX_W'(1);
    end
    if (push_c) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // STALL takes priority so VEC_LEN==1 also blocks on a full FIFO
    if ((idx_d == LAST_IDX) && (level_d == FULL_LVL)) begin
      state_d = STALL;
    end else if (idx_d == '0) begin
      state_d = IDLE;
    end else begin
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Assembly lanes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= '0;
      lane_sat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < VEC_LEN; i++) begin
        if (accept_c && (idx_q == IDX_W'(i))) begin
          lane_q[i]     <= elem_c;
          lane_sat_q[i] <= elem_sat_c;
        end
      end
    end
  end

  // Vector storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]     <= '0;
        sat_mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q]     <= push_vec_c;
      sat_mem_q[wr_ptr_q] <= push_sat_c;
    end
  end

endmodule
